// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N:1 mux between N requesters, with a per-tenure
// hold cap and a registered mux output stage.
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    grant,
  output logic [SEL_W-1:0] sel,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  output logic            busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, win;
  logic [N-1:0]     grant_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             found, keep;

  // Descending scan so the smallest offset from ptr is the last (winning) assignment;
  // SEL_W-bit addition wraps modulo N because N is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        win   = ptr + SEL_W'(k);
      end
    end
  end

  assign keep = req[sel] && (hold_cnt < HW'(MAX_HOLD));

  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = grant;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    if (state == GRANT && keep) begin
      hold_n = hold_cnt + HW'(1);
    end else if (found) begin
      state_n = GRANT;
      sel_n   = win;
      grant_n = ONE << win;
      hold_n  = HW'(1);
      ptr_n   = win + SEL_W'(1);
    end else begin
      state_n = IDLE;
      grant_n = '0;
      hold_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      grant     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      grant     <= grant_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      out_valid <= (state == GRANT);
      if (state == GRANT) out_data <= in_data[sel*DW +: DW];
    end
  end

  assign busy = (state == GRANT);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: an integer-level model predicts each edge's
// outputs into a queue, and a monitor compares them against the DUT after the edge.
module tb_mux_rr_arbiter;
  localparam int N = 8, SEL_W = 3, DW = 1, MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '1;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    grant;
  logic [SEL_W-1:0] sel;
  logic [DW-1:0]   out_data;
  logic            out_valid, busy;

  int checks = 0, failures = 0;

  mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .grant(grant),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [SEL_W-1:0] s;
    logic b, od, ov;
  } exp_t;
  exp_t q[$];

  // Reference model: current owner (or none), tenure length, rotation start.
  int m_busy, m_sel, m_cnt, m_ptr;
  logic m_od;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_cnt = 0; m_ptr = 0; m_od = 1'b0;
      q.delete();
    end else begin
      exp_t e;
      int w;
      e.ov = (m_busy != 0);
      if (m_busy != 0) m_od = in_data[m_sel];
      e.od = m_od;
      if (m_busy != 0 && req[m_sel] && m_cnt < MAX_HOLD) begin
        m_cnt++;
      end else begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_busy = 1; m_sel = w; m_cnt = 1; m_ptr = (w + 1) % N;
        end else begin
          m_busy = 0; m_cnt = 0;
        end
      end
      e.b = (m_busy != 0);
      e.s = SEL_W'(m_sel);
      e.g = (m_busy != 0) ? (N'(1) << m_sel) : '0;
      q.push_back(e);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: no expected entry at t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({grant, sel, busy, out_data, out_valid} !== {e.g, e.s, e.b, e.od, e.ov}) begin
          failures++;
          $display("FAIL sb_outputs t=%0t: got grant=%h sel=%0d busy=%b od=%b ov=%b, want grant=%h sel=%0d busy=%b od=%b ov=%b",
                   $time, grant, sel, busy, out_data, out_valid, e.g, e.s, e.b, e.od, e.ov);
        end
      end
      checks++;
      if (!$onehot0(grant) || (busy && grant !== (N'(1) << sel))) begin
        failures++;
        $display("FAIL grant_onehot t=%0t: got grant=%h sel=%0d busy=%b, want one-hot matching sel", $time, grant, sel, busy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called on a negedge; drives inputs and advances n cycles.
  task automatic run(input logic [N-1:0] r, input logic [N*DW-1:0] d, input int n);
    req = r;
    in_data = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 chk_reset_outputs("reset_t0");
    @(posedge clk); #1 chk_reset_outputs("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hFF, 8'h5A, 40);
    run(8'h08, 8'h08, 10);
    run(8'h00, 8'h00, 2);
    run(8'h04, 8'h04, 2);
    run(8'h85, 8'h81, 2);
    run(8'h81, 8'h80, 6);
    run(8'h04, 8'h04, 3);
    run(8'h02, 8'h04, 3);
    run(8'h00, 8'h00, 3);
    run(8'h20, 8'h20, 3);
    chk("mid_tenure_sel", 32'(sel), 5);
    rst_n = 1'b0;
    #1 chk_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hFF, 8'hFF, 3);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        #1 chk_reset_outputs("reset_rand");
        @(negedge clk);
        rst_n = 1'b1;
      end
      run(N'($urandom & $urandom), N'($urandom), int'($urandom_range(1, 6)));
    end
    @(posedge clk); #2;
    chk("sb_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
